// File: rtl/led_counter_bank_if.sv
// Configuration and status bundle for led_counter_bank: counter controls, trigger setup,
// counter/LED/terminal-count outputs and the trigger flags.
interface led_counter_bank_if #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int LED_BITS   = 4,
  parameter int PRESCALE_W = 8
);
  logic [PRESCALE_W-1:0]      prescale;
  logic [NUM_CH-1:0]          ch_en;
  logic [NUM_CH-1:0]          ch_dir;
  logic [NUM_CH-1:0]          ch_sat;
  logic [NUM_CH-1:0]          load;
  logic [NUM_CH*CNT_W-1:0]    load_val;
  logic [3:0]                 trig_ch;
  logic [CNT_W-1:0]           trig_val;
  logic                       trig_arm;
  logic [NUM_CH*CNT_W-1:0]    cnt_out;
  logic [NUM_CH*LED_BITS-1:0] led;
  logic [NUM_CH-1:0]          tc;
  logic                       trig_out;
  logic                       trig_hold;

  modport master (
    output prescale, ch_en, ch_dir, ch_sat, load, load_val, trig_ch, trig_val, trig_arm,
    input  cnt_out, led, tc, trig_out, trig_hold
  );

  modport slave (
    input  prescale, ch_en, ch_dir, ch_sat, load, load_val, trig_ch, trig_val, trig_arm,
    output cnt_out, led, tc, trig_out, trig_hold
  );
endinterface

// File: rtl/led_counter_bank.sv
// Multi-channel counter bank with shared prescaler, per-channel wrap/saturate counting,
// LED taps from the counter top bits and an armable compare trigger.
//   state | meaning
//   IDLE  | trigger not armed since reset
//   ARMED | waiting for cnt_out[trig_ch] == trig_val
//   FIRED | trigger has fired, trig_hold set until re-armed
module led_counter_bank #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int LED_BITS   = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic         clk1,
  input  logic         rstn,
  led_counter_bank_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, FIRED} trig_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PRESCALE_W-1:0]      pre_cnt;
  logic                       tick;
  logic [NUM_CH*CNT_W-1:0]    cnt_flat;
  logic [NUM_CH*LED_BITS-1:0] led_flat;
  logic [NUM_CH-1:0]          tc_flat;
  logic                       match;
  trig_state_t                state, state_nxt;
  logic                       fire;
  logic                       hold_nxt;
  logic                       trig_out_q;
  logic                       trig_hold_q;

  // A prescale lowered below the running count ticks on the very next cycle.
  assign tick = (pre_cnt >= bus.prescale);

  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn)     pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] term;
    logic             at_term;
    logic             tc_q;

    always_comb begin
      term    = bus.ch_dir[i] ? CNT_MAX : '0;
      at_term = (cnt_q == term);
      cnt_nxt = bus.ch_dir[i] ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end

    // Wrap mode flags tc on the wrap itself; saturate mode flags the step that lands on terminal.
    always_ff @(posedge clk1 or negedge rstn) begin
      if (!rstn) begin
        cnt_q <= '0;
        tc_q  <= 1'b0;
      end else begin
        tc_q <= 1'b0;
        if (bus.load[i]) begin
          cnt_q <= bus.load_val[i*CNT_W +: CNT_W];
        end else if (tick && bus.ch_en[i]) begin
          if (bus.ch_sat[i]) begin
            if (!at_term) begin
              cnt_q <= cnt_nxt;
              tc_q  <= (cnt_nxt == term);
            end
          end else begin
            cnt_q <= cnt_nxt;
            tc_q  <= at_term;
          end
        end
      end
    end

    assign cnt_flat[i*CNT_W +: CNT_W]       = cnt_q;
    assign led_flat[i*LED_BITS +: LED_BITS] = cnt_q[CNT_W-1 -: LED_BITS];
    assign tc_flat[i]                       = tc_q;
  end

  always_comb begin
    match = 1'b0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (bus.trig_ch == 4'(j) && cnt_flat[j*CNT_W +: CNT_W] == bus.trig_val) match = 1'b1;
    end
  end

  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      trig_out_q  <= 1'b0;
      trig_hold_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      trig_out_q  <= fire;
      trig_hold_q <= hold_nxt;
    end
  end

  // Match is only looked at in ARMED, so a match coinciding with arm acceptance is ignored.
  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    hold_nxt  = trig_hold_q;
    case (state)
      IDLE, FIRED: begin
        if (bus.trig_arm) begin
          state_nxt = ARMED;
          hold_nxt  = 1'b0;
        end
      end
      ARMED: begin
        if (match) begin
          state_nxt = FIRED;
          fire      = 1'b1;
          hold_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cnt_out   = cnt_flat;
  assign bus.led       = led_flat;
  assign bus.tc        = tc_flat;
  assign bus.trig_out  = trig_out_q;
  assign bus.trig_hold = trig_hold_q;

endmodule

// File: tb/tb_led_counter_bank.sv
// Directed and randomized bench for led_counter_bank, checked cycle by cycle against a
// behavioural model of the counters, prescaler and trigger.
module tb_led_counter_bank;
  localparam int NUM_CH     = 4;
  localparam int CNT_W      = 8;
  localparam int LED_BITS   = 4;
  localparam int PRESCALE_W = 8;
  localparam int MAXV       = (1 << CNT_W) - 1;

  logic clk1;
  logic rstn;

  led_counter_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .LED_BITS(LED_BITS),
                        .PRESCALE_W(PRESCALE_W)) bus ();

  led_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .LED_BITS(LED_BITS),
                     .PRESCALE_W(PRESCALE_W)) dut (
    .clk1 (clk1),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int checks = 0;
  int errors = 0;

  // Model state: counter values as integers, cycles since last tick, trigger as armed/hold flags.
  int m_cnt [NUM_CH];
  bit m_tc  [NUM_CH];
  int m_pre;
  bit m_armed, m_hold, m_trig;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i] = 0;
      m_tc[i]  = 0;
    end
    m_pre   = 0;
    m_armed = 0;
    m_hold  = 0;
    m_trig  = 0;
  endtask

  task automatic model_update();
    bit tick;
    bit match;
    tick  = (m_pre >= int'(bus.prescale));
    m_pre = tick ? 0 : m_pre + 1;
    match = 0;
    if (int'(bus.trig_ch) < NUM_CH) match = (m_cnt[bus.trig_ch] == int'(bus.trig_val));
    m_trig = 0;
    if (m_armed) begin
      if (match) begin
        m_armed = 0;
        m_hold  = 1;
        m_trig  = 1;
      end
    end else if (bus.trig_arm) begin
      m_armed = 1;
      m_hold  = 0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      int terminal;
      m_tc[i]  = 0;
      terminal = bus.ch_dir[i] ? MAXV : 0;
      if (bus.load[i]) begin
        m_cnt[i] = int'(bus.load_val[i*CNT_W +: CNT_W]);
      end else if (tick && bus.ch_en[i]) begin
        if (m_cnt[i] == terminal) begin
          if (!bus.ch_sat[i]) begin
            m_cnt[i] = MAXV - terminal;
            m_tc[i]  = 1;
          end
        end else begin
          m_cnt[i] = bus.ch_dir[i] ? m_cnt[i] + 1 : m_cnt[i] - 1;
          m_tc[i]  = bus.ch_sat[i] && (m_cnt[i] == terminal);
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [NUM_CH*CNT_W-1:0]    exp_cnt;
    logic [NUM_CH*LED_BITS-1:0] exp_led;
    logic [NUM_CH-1:0]          exp_tc;
    for (int i = 0; i < NUM_CH; i++) begin
      exp_cnt[i*CNT_W +: CNT_W]       = CNT_W'(m_cnt[i]);
      exp_led[i*LED_BITS +: LED_BITS] = LED_BITS'(m_cnt[i] >> (CNT_W - LED_BITS));
      exp_tc[i]                       = m_tc[i];
    end
    checks++;
    assert (bus.cnt_out === exp_cnt) else begin
      errors++; $error("FAIL cnt_out got %h exp %h", bus.cnt_out, exp_cnt);
    end
    checks++;
    assert (bus.led === exp_led) else begin
      errors++; $error("FAIL led got %h exp %h", bus.led, exp_led);
    end
    checks++;
    assert (bus.tc === exp_tc) else begin
      errors++; $error("FAIL tc got %b exp %b", bus.tc, exp_tc);
    end
    checks++;
    assert (bus.trig_out === m_trig) else begin
      errors++; $error("FAIL trig_out got %b exp %b", bus.trig_out, m_trig);
    end
    checks++;
    assert (bus.trig_hold === m_hold) else begin
      errors++; $error("FAIL trig_hold got %b exp %b", bus.trig_hold, m_hold);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk1);
    @(negedge clk1);
    check_outputs();
  endtask

  task automatic check_all_zero(input string tag);
    logic [NUM_CH*CNT_W-1:0] zc;
    zc = '0;
    checks++;
    assert (bus.cnt_out === zc && bus.led === '0 && bus.tc === '0 &&
            bus.trig_out === 1'b0 && bus.trig_hold === 1'b0) else begin
      errors++;
      $error("FAIL %s got cnt=%h led=%h tc=%b to=%b th=%b exp all zero", tag,
             bus.cnt_out, bus.led, bus.tc, bus.trig_out, bus.trig_hold);
    end
  endtask

  initial begin
    int pulses;
    bit fired;
    int exp_seq [5];
    logic [CNT_W-1:0] c;

    rstn         = 1'b0;
    bus.prescale = '0;
    bus.ch_en    = '0;
    bus.ch_dir   = '0;
    bus.ch_sat   = '0;
    bus.load     = '0;
    bus.load_val = '0;
    bus.trig_ch  = '0;
    bus.trig_val = '0;
    bus.trig_arm = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk1);
    rstn = 1'b1;
    step();

    // T1: prescale 3, ch0 up/wrap from FE; one tc pulse on the wrap
    bus.prescale = 8'd3;
    bus.ch_en    = 4'b0001;
    bus.ch_dir   = 4'b0001;
    bus.load     = 4'b0001;
    bus.load_val[7:0] = 8'hFE;
    step();
    bus.load = '0;
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (bus.tc[0]) begin
        pulses++;
        checks++;
        assert (bus.cnt_out[7:0] === 8'h00) else begin
          errors++; $error("FAIL t1_wrap_val got %h exp 00", bus.cnt_out[7:0]);
        end
      end
    end
    checks++;
    assert (pulses == 1) else begin
      errors++; $error("FAIL t1_tc_pulses got %0d exp 1", pulses);
    end

    // T2: ch1 down/sat from 2 at prescale 0 -> 2,1,0,0,0 with a single tc
    bus.prescale = '0;
    bus.ch_en    = 4'b0010;
    bus.ch_dir   = 4'b0000;
    bus.ch_sat   = 4'b0010;
    bus.load     = 4'b0010;
    bus.load_val[15:8] = 8'd2;
    exp_seq = '{2, 1, 0, 0, 0};
    pulses  = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      bus.load = '0;
      if (bus.tc[1]) pulses++;
      checks++;
      assert (int'(bus.cnt_out[15:8]) == exp_seq[k]) else begin
        errors++; $error("FAIL t2_seq%0d got %0d exp %0d", k, bus.cnt_out[15:8], exp_seq[k]);
      end
    end
    checks++;
    assert (pulses == 1) else begin
      errors++; $error("FAIL t2_tc_pulses got %0d exp 1", pulses);
    end

    // T3: load beats a coincident tick on ch2
    bus.ch_en  = 4'b0100;
    bus.ch_dir = 4'b0100;
    bus.ch_sat = '0;
    bus.load   = 4'b0100;
    bus.load_val[23:16] = 8'd5;
    step();
    bus.load = '0;
    checks++;
    assert (bus.cnt_out[23:16] === 8'd5 && bus.tc[2] === 1'b0) else begin
      errors++; $error("FAIL t3_load_prio got cnt=%0d tc=%b exp 5 0", bus.cnt_out[23:16], bus.tc[2]);
    end
    step();

    // T4: trigger on ch0 == 10, then re-arm and fire on the next pass
    bus.ch_en  = 4'b0001;
    bus.ch_dir = 4'b0001;
    bus.load   = 4'b0001;
    bus.load_val[7:0] = 8'd0;
    step();
    bus.load     = '0;
    bus.trig_ch  = 4'd0;
    bus.trig_val = 8'd10;
    for (int pass = 0; pass < 2; pass++) begin
      bus.trig_arm = 1'b1;
      step();
      bus.trig_arm = 1'b0;
      checks++;
      assert (bus.trig_hold === 1'b0) else begin
        errors++; $error("FAIL t4_arm_clear%0d got %b exp 0", pass, bus.trig_hold);
      end
      fired = 0;
      for (int k = 0; k < 300 && !fired; k++) begin
        step();
        if (bus.trig_out) fired = 1;
      end
      checks++;
      assert (fired) else begin
        errors++; $error("FAIL t4_fire%0d got no trig_out exp pulse within 300 cycles", pass);
      end
      c = bus.cnt_out[7:0];
      checks++;
      assert (c === 8'd11 && bus.trig_hold === 1'b1) else begin
        errors++; $error("FAIL t4_latency%0d got cnt=%0d hold=%b exp 11 1", pass, c, bus.trig_hold);
      end
      step();
    end

    // T5: trigger channel out of range never fires
    bus.trig_ch  = 4'(NUM_CH);
    bus.trig_arm = 1'b1;
    step();
    bus.trig_arm = 1'b0;
    pulses = 0;
    for (int k = 0; k < 260; k++) begin
      step();
      if (bus.trig_out) pulses++;
    end
    checks++;
    assert (pulses == 0) else begin
      errors++; $error("FAIL t5_no_trig got %0d pulses exp 0", pulses);
    end

    // T6: asynchronous reset mid-count, resume from 0 with prescale 2
    bus.ch_en = 4'b1111;
    for (int k = 0; k < 5; k++) step();
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("t6_async_reset");
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    check_all_zero("t6_reset_hold");
    model_reset();
    bus.prescale = 8'd2;
    rstn = 1'b1;
    for (int k = 0; k < 10; k++) step();

    // Randomized phase
    for (int k = 0; k < 1500; k++) begin
      bus.prescale = PRESCALE_W'($urandom_range(0, 3));
      bus.ch_en    = NUM_CH'($urandom);
      if ($urandom_range(0, 7) == 0) bus.ch_dir = NUM_CH'($urandom);
      if ($urandom_range(0, 7) == 0) bus.ch_sat = NUM_CH'($urandom);
      bus.load = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 19) == 0) begin
          bus.load[i] = 1'b1;
          case ($urandom_range(0, 4))
            0: bus.load_val[i*CNT_W +: CNT_W] = 8'h00;
            1: bus.load_val[i*CNT_W +: CNT_W] = 8'h01;
            2: bus.load_val[i*CNT_W +: CNT_W] = 8'hFE;
            3: bus.load_val[i*CNT_W +: CNT_W] = 8'hFF;
            default: bus.load_val[i*CNT_W +: CNT_W] = CNT_W'($urandom);
          endcase
        end
      end
      if ($urandom_range(0, 15) == 0) begin
        bus.trig_ch  = 4'($urandom_range(0, 5));
        bus.trig_val = CNT_W'(m_cnt[bus.trig_ch % NUM_CH] + int'($urandom_range(0, 3)));
      end
      bus.trig_arm = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
